pkt_byte_fifo: RTL and testbench
================================

// Module: pkt_byte_fifo
// PURPOSE
//  Packet-granular FIFO between the correlator result packer and the bytepipe register block.
//  Whole result packets (PKT_BYTES wide) are pushed in a single cycle.
//  Bytes are popped one at a time through the pktfifo read port (data/empty/pop/flush).
//  Capacity is counted in packets. Pushes to a full FIFO drop the whole packet; packets never tear.
// PARAMETERS
//  DEPTH      10  packet slots, >=2, need not be a power of 2
//  PKT_BYTES  8   bytes per packet, >=2
// PORTS
//  i_clk       in   1                    clock, all state on rising edge
//  i_rst_n     in   1                    asynchronous active-low reset
//  i_cg        in   1                    clock-gate enable; 0 freezes all state, push/pop/flush ignored
//  i_pkt_data  in   8*PKT_BYTES          packet; byte k = bits [8k+7:8k]
//  i_pkt_valid in   1                    push request, 1-cycle pulse per packet, no backpressure
//  o_data      out  8                    head byte of head packet
//  o_empty     out  1                    no complete packet byte available
//  i_pop       in   1                    consume o_data this cycle
//  i_flush     in   1                    discard all contents
//  o_level     out  $clog2(DEPTH+1)      packets stored, including a partially read head
//  o_dropCnt   out  8                    packets dropped on overflow (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: rdPtr=wrPtr=0, byteIdx=0, level=0, dropCnt=0. o_empty=1, o_level=0, o_data=0.
//  - Storage is DEPTH x (8*PKT_BYTES) regs, not reset. o_data is forced to 0 while o_empty.
//  - Read is combinational: o_data=mem[rdPtr][8*byteIdx+:8], valid in the same cycle as !o_empty (0-latency).
//  - Byte order is byte 0 first, byte PKT_BYTES-1 last.
//  - pop && !o_empty: byteIdx++. On the last byte (byteIdx==PKT_BYTES-1), byteIdx->0, rdPtr advances, level--.
//  - pop && o_empty: ignored; no state change, no error.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (modulo DEPTH, not power of 2).
//  - Push is accepted iff level<DEPTH, or a last-byte pop occurs in the same cycle.
//    Accepted: mem[wrPtr]<=i_pkt_data, wrPtr advances, level++.
//  - Push and last-byte pop in the same cycle: level is unchanged.
//  - Rejected push (full, no retiring pop): packet discarded, drop event raised.
//  - Push to an empty FIFO: o_empty falls the next cycle. The written byte is never bypassed.
//  - Flush: next cycle ptrs=0, byteIdx=0, level=0, dropCnt=0 (if present).
//    Flush beats push and pop in the same cycle: both are discarded, and a rejected push raises no drop.
//  - Flush mid-packet discards the partially read head. A following push restarts at byte 0.
//  - o_level is stable within a packet; it drops only on the last-byte pop.
//  - Async reset mid-read or mid-push: all state returns to reset values immediately. No partial packet survives.
//  - All next-state logic is qualified by i_cg.
// CONFIGURATION
//  PKT_BYTE_FIFO_DROPCNT_EN defined:
//    o_dropCnt is an 8b counter, +1 per rejected push.
//    It saturates at 255, with no wrap, and is cleared by flush or reset.
//  Not defined:
//    o_dropCnt is tied to 0 and no counter flops exist. Push/pop/flush behaviour is identical.
// TESTING
//  1. Reset, then push 0x0807060504030201 (PKT_BYTES=8). Next cycle o_empty=0, o_level=1, o_data=0x01.
//     8 pops give 01..08, then o_empty=1, o_level=0.
//  2. Push 11 distinct packets with no pops (DEPTH=10): o_level=10, o_dropCnt=1 (EN) or 0 (not EN).
//     Drain 80 bytes: packets 1..10 come out in order and packet 11 is absent.
//  3. Fill 10, read 7 bytes of head, then push + last-byte pop in the same cycle:
//     push accepted, o_level stays 10, o_dropCnt unchanged. Wrap to slot 0 verified by drain order.
//  4. Fill 3, pop 3 bytes, assert flush+push+pop in one cycle:
//     next cycle o_empty=1, o_level=0, o_dropCnt=0. Next push reads out from byte 0.
//  5. Pop on empty for 5 cycles: no state change, o_data=0. Push 260 packets while full (EN): o_dropCnt=255.
//  6. Deassert i_rst_n mid-packet (after 3 byte pops, pointers wrapped):
//     o_empty=1, o_level=0 immediately, without a clock edge. i_cg=0 with push/pop/flush asserted gives no change.

Source files
------------

// File: rtl/pkt_byte_fifo.sv
// Packet-granular FIFO: whole packets pushed in one cycle, popped a byte at a time.
// Optional drop counter enabled by defining PKT_BYTE_FIFO_DROPCNT_EN.
module pkt_byte_fifo #(
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned PKT_BYTES = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cg,
  input  logic [8*PKT_BYTES-1:0]       i_pkt_data,
  input  logic                         i_pkt_valid,
  output logic [7:0]                   o_data,
  output logic                         o_empty,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic [7:0]                   o_dropCnt
);

  localparam int unsigned PKT_W = 8 * PKT_BYTES;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned IDX_W = $clog2(PKT_BYTES);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [PKT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic empty;
  logic pop_ok;
  logic last_pop;
  logic push_ok;
  logic drop;
  logic mem_we;

  assign empty    = (level_q == '0);
  assign pop_ok   = i_pop && !empty;
  assign last_pop = pop_ok && (byte_idx_q == IDX_W'(PKT_BYTES - 1));
  // A retiring last-byte pop frees a slot in the same cycle, so a push into a full FIFO still fits.
  assign push_ok  = i_pkt_valid && ((level_q < LVL_W'(DEPTH)) || last_pop);
  assign drop     = i_cg && !i_flush && i_pkt_valid && !push_ok;
  assign mem_we   = i_cg && !i_flush && push_ok;

  // Pointer, byte index and level next-state
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    byte_idx_d = byte_idx_q;
    level_d    = level_q;
    if (i_cg) begin
      if (i_flush) begin
        rd_ptr_d   = '0;
        wr_ptr_d   = '0;
        byte_idx_d = '0;
        level_d    = '0;
      end else begin
        if (pop_ok) begin
          if (last_pop) begin
            byte_idx_d = '0;
            rd_ptr_d   = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
        if (push_ok) begin
          wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, last_pop})
          2'b10:   level_d = level_q + LVL_W'(1);
          2'b01:   level_d = level_q - LVL_W'(1);
          default: level_d = level_q;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      byte_idx_q <= '0;
      level_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_idx_q <= byte_idx_d;
      level_q    <= level_d;
    end
  end

  // Packet storage is intentionally not reset; validity is tracked by level_q alone.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= i_pkt_data;
    end
  end

  assign o_empty = empty;
  assign o_level = level_q;
  assign o_data  = empty ? 8'h00 : mem_q[rd_ptr_q][{byte_idx_q, 3'b000} +: 8];

`ifdef PKT_BYTE_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of rejected pushes; cleared by flush
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_cg) begin
      if (i_flush) begin
        drop_cnt_d = '0;
      end else if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_dropCnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign o_dropCnt   = 8'h00;
`endif

endmodule

// File: tb/tb_pkt_byte_fifo.sv
// Self-checking bench for pkt_byte_fifo using a byte-queue scoreboard.
module tb_pkt_byte_fifo;

  localparam int DEPTH = 10;
  localparam int PB    = 8;

  logic          clk;
  logic          rst_n;
  logic          cg;
  logic [63:0]   pkt_data;
  logic          pkt_valid;
  logic [7:0]    data;
  logic          empty;
  logic          pop;
  logic          flush;
  logic [3:0]    level;
  logic [7:0]    drop_cnt;

  int n_checks;
  int n_err;
  int exp_drop;
  logic [7:0] exp_q[$];

  pkt_byte_fifo #(.DEPTH(DEPTH), .PKT_BYTES(PB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_pkt_data(pkt_data),
    .i_pkt_valid(pkt_valid), .o_data(data), .o_empty(empty), .i_pop(pop),
    .i_flush(flush), .o_level(level), .o_dropCnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] make_pkt(input int n);
    logic [63:0] p;
    for (int k = 0; k < PB; k++) p[8*k +: 8] = 8'((n * 16 + k) & 8'hFF);
    return p;
  endfunction

  function automatic int mlevel();
    return (exp_q.size() + PB - 1) / PB;
  endfunction

  function automatic int exp_dc();
`ifdef PKT_BYTE_FIFO_DROPCNT_EN
    return (exp_drop > 255) ? 255 : exp_drop;
`else
    return 0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_push(input logic [63:0] p);
    for (int k = 0; k < PB; k++) exp_q.push_back(p[8*k +: 8]);
  endtask

  // Drive one push cycle and update the model (no pop in the same cycle)
  task automatic push_pkt(input logic [63:0] p);
    pkt_data  = p;
    pkt_valid = 1'b1;
    if (mlevel() < DEPTH) model_push(p);
    else exp_drop++;
    cyc();
    pkt_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cg = 1'b1; pkt_valid = 1'b0; pop = 1'b0; flush = 1'b0; pkt_data = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (empty !== 1'b1 || level !== 4'd0 || data !== 8'h00 || drop_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL reset: empty=%b level=%0d data=%h drop=%0d, need 1 0 00 0", empty, level, data, drop_cnt);
    end
  endtask

  task automatic test_basic();
    push_pkt(64'h0807060504030201);
    n_checks++;
    if (empty !== 1'b0 || level !== 4'd1 || data !== 8'h01) begin
      n_err++;
      $display("FAIL basic_first: empty=%b level=%0d data=%h, need 0 1 01", empty, level, data);
    end
    for (int i = 0; i < PB; i++) begin
      n_checks++;
      if (empty !== 1'b0 || data !== exp_q[0]) begin
        n_err++;
        $display("FAIL basic_byte%0d: empty=%b data=%h, need 0 %h", i, empty, data, exp_q[0]);
      end
      pop = 1'b1; cyc(); pop = 1'b0;
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (empty !== 1'b1 || level !== 4'd0) begin
      n_err++;
      $display("FAIL basic_end: empty=%b level=%0d, need 1 0", empty, level);
    end
  endtask

  task automatic test_overflow();
    for (int n = 1; n <= 11; n++) push_pkt(make_pkt(n));
    n_checks++;
    if (level !== 4'd10 || drop_cnt !== 8'(exp_dc())) begin
      n_err++;
      $display("FAIL ovf_level: level=%0d drop=%0d, need 10 %0d", level, drop_cnt, exp_dc());
    end
    for (int i = 0; i < DEPTH * PB; i++) begin
      n_checks++;
      if (empty !== 1'b0 || data !== exp_q[0] || level !== 4'(mlevel())) begin
        n_err++;
        $display("FAIL ovf_drain%0d: empty=%b data=%h level=%0d, need 0 %h %0d",
                 i, empty, data, level, exp_q[0], mlevel());
      end
      pop = 1'b1; cyc(); pop = 1'b0;
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (empty !== 1'b1 || data !== 8'h00) begin
      n_err++;
      $display("FAIL ovf_empty: empty=%b data=%h, need 1 00", empty, data);
    end
  endtask

  task automatic test_push_pop_same();
    for (int n = 20; n < 30; n++) push_pkt(make_pkt(n));
    for (int i = 0; i < 7; i++) begin
      pop = 1'b1; cyc(); pop = 1'b0;
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (level !== 4'd10 || data !== exp_q[0]) begin
      n_err++;
      $display("FAIL ppsame_pre: level=%0d data=%h, need 10 %h", level, data, exp_q[0]);
    end
    pkt_data = make_pkt(30); pkt_valid = 1'b1; pop = 1'b1;
    cyc();
    pkt_valid = 1'b0; pop = 1'b0;
    void'(exp_q.pop_front());
    model_push(make_pkt(30));
    n_checks++;
    if (level !== 4'd10 || drop_cnt !== 8'(exp_dc())) begin
      n_err++;
      $display("FAIL ppsame_level: level=%0d drop=%0d, need 10 %0d", level, drop_cnt, exp_dc());
    end
    for (int i = 0; i < DEPTH * PB; i++) begin
      n_checks++;
      if (empty !== 1'b0 || data !== exp_q[0]) begin
        n_err++;
        $display("FAIL ppsame_drain%0d: empty=%b data=%h, need 0 %h", i, empty, data, exp_q[0]);
      end
      pop = 1'b1; cyc(); pop = 1'b0;
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (empty !== 1'b1 || level !== 4'd0) begin
      n_err++;
      $display("FAIL ppsame_end: empty=%b level=%0d, need 1 0", empty, level);
    end
  endtask

  task automatic test_flush();
    for (int n = 40; n < 43; n++) push_pkt(make_pkt(n));
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1; cyc(); pop = 1'b0;
      void'(exp_q.pop_front());
    end
    pkt_data = make_pkt(50); pkt_valid = 1'b1; pop = 1'b1; flush = 1'b1;
    cyc();
    pkt_valid = 1'b0; pop = 1'b0; flush = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    n_checks++;
    if (empty !== 1'b1 || level !== 4'd0 || drop_cnt !== 8'h00 || data !== 8'h00) begin
      n_err++;
      $display("FAIL flush: empty=%b level=%0d drop=%0d data=%h, need 1 0 0 00", empty, level, drop_cnt, data);
    end
    push_pkt(make_pkt(51));
    for (int i = 0; i < PB; i++) begin
      n_checks++;
      if (empty !== 1'b0 || data !== exp_q[0]) begin
        n_err++;
        $display("FAIL flush_restart%0d: empty=%b data=%h, need 0 %h", i, empty, data, exp_q[0]);
      end
      pop = 1'b1; cyc(); pop = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_empty_pop_and_sat();
    for (int i = 0; i < 5; i++) begin
      pop = 1'b1; cyc(); pop = 1'b0;
      n_checks++;
      if (empty !== 1'b1 || level !== 4'd0 || data !== 8'h00) begin
        n_err++;
        $display("FAIL empty_pop%0d: empty=%b level=%0d data=%h, need 1 0 00", i, empty, level, data);
      end
    end
    for (int n = 60; n < 70; n++) push_pkt(make_pkt(n));
    for (int n = 0; n < 260; n++) push_pkt(make_pkt(n + 100));
    n_checks++;
    if (level !== 4'd10 || drop_cnt !== 8'(exp_dc())) begin
      n_err++;
      $display("FAIL drop_sat: level=%0d drop=%0d, need 10 %0d", level, drop_cnt, exp_dc());
    end
  endtask

  task automatic test_async_reset_and_cg();
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1; cyc(); pop = 1'b0;
      void'(exp_q.pop_front());
    end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_drop = 0;
    n_checks++;
    if (empty !== 1'b1 || level !== 4'd0 || drop_cnt !== 8'h00 || data !== 8'h00) begin
      n_err++;
      $display("FAIL async_rst: empty=%b level=%0d drop=%0d data=%h, need 1 0 0 00", empty, level, drop_cnt, data);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    push_pkt(make_pkt(90));
    cg = 1'b0;
    pkt_data = make_pkt(91); pkt_valid = 1'b1; pop = 1'b1; flush = 1'b1;
    repeat (4) cyc();
    pkt_valid = 1'b0; pop = 1'b0; flush = 1'b0;
    n_checks++;
    if (empty !== 1'b0 || level !== 4'd1 || data !== exp_q[0] || drop_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL cg_freeze: empty=%b level=%0d data=%h drop=%0d, need 0 1 %h 0",
               empty, level, data, drop_cnt, exp_q[0]);
    end
    cg = 1'b1;
    for (int i = 0; i < PB; i++) begin
      n_checks++;
      if (empty !== 1'b0 || data !== exp_q[0]) begin
        n_err++;
        $display("FAIL cg_drain%0d: empty=%b data=%h, need 0 %h", i, empty, data, exp_q[0]);
      end
      pop = 1'b1; cyc(); pop = 1'b0;
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (empty !== 1'b1 || level !== 4'd0) begin
      n_err++;
      $display("FAIL cg_end: empty=%b level=%0d, need 1 0", empty, level);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    exp_drop = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_push_pop_same();
    test_flush();
    test_empty_pop_and_sat();
    test_async_reset_and_cg();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
